// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: FSM state encoding and default bit-region base for ram_arbiter.
// The RMW states exist only when RAM_ARB_BITOP_EN is defined.
package ram_arb_pkg;
`ifdef RAM_ARB_BITOP_EN
    typedef enum logic [1:0] {IDLE, ACC, RMW_RD, RMW_WR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC} state_t;
`endif
    localparam logic [7:0] BIT_BASE_DEFAULT = 8'h20;
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-requester round-robin pick; favours core out of reset.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic core_req,
    input  logic dbg_req,
    input  logic grant,
    output logic pick_dbg
);
    logic favour_dbg;
    assign pick_dbg = dbg_req & (~core_req | favour_dbg);
    always_ff @(posedge clock) begin
        if (reset)
            favour_dbg <= 1'b0;
        else if (grant & (core_req | dbg_req))
            favour_dbg <= ~pick_dbg;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin core/debug arbiter in front of a single data RAM.
// Define RAM_ARB_BITOP_EN to compile in core bit read-modify-write operations.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter logic [7:0] BIT_BASE = BIT_BASE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       core_req,
    input  logic       core_we,
    input  logic       core_bit,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_gnt,
    output logic       core_done,
    output logic       core_err,
    output logic [7:0] core_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_gnt,
    output logic       dbg_done,
    output logic [7:0] dbg_rdata,
    output logic       ram_rd_en_data,
    output logic       ram_wr_en_data,
    output logic [7:0] ram_rd_addr,
    output logic [7:0] ram_wr_addr,
    output logic [7:0] ram_wr_byte,
    input  logic [7:0] ram_rd_byte
);
    state_t state, state_n;
    logic pick_dbg, any_req, cap_dbg, cap_we;
    logic [7:0] cap_addr, cap_wdata;
    assign any_req = core_req | dbg_req;
    ram_arb_rr u_rr (
        .clock    (clock),
        .reset    (reset),
        .core_req (core_req),
        .dbg_req  (dbg_req),
        .grant    (state == IDLE),
        .pick_dbg (pick_dbg)
    );
`ifdef RAM_ARB_BITOP_EN
    logic win_bit, sfr_rej, err_q;
    logic [7:0] rmw_byte, bit_byte, bit_merged;
    assign win_bit = ~pick_dbg & core_bit & core_we;
    assign sfr_rej = (state == IDLE) & any_req & win_bit & core_addr[7];
    assign core_err = err_q;
    assign bit_byte = BIT_BASE + {4'd0, cap_addr[6:3]};
    assign bit_merged = (rmw_byte & ~(8'd1 << cap_addr[2:0])) | ({7'd0, cap_wdata[0]} << cap_addr[2:0]);
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
            rmw_byte <= 8'h00;
        end else begin
            err_q <= sfr_rej;
            if (state == RMW_RD) rmw_byte <= ram_rd_byte;
        end
    end
`else
    localparam logic [7:0] UNUSED_BASE = BIT_BASE;
    logic unused_bit;
    assign unused_bit = core_bit;
    assign core_err = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cap_dbg <= 1'b0;
            cap_we <= 1'b0;
            cap_addr <= 8'h00;
            cap_wdata <= 8'h00;
            core_done <= 1'b0;
            dbg_done <= 1'b0;
            core_rdata <= 8'h00;
            dbg_rdata <= 8'h00;
        end else begin
            state <= state_n;
            core_done <= 1'b0;
            dbg_done <= 1'b0;
            if (state == IDLE && any_req) begin
                cap_dbg <= pick_dbg;
                cap_we <= pick_dbg ? dbg_we : core_we;
                cap_addr <= pick_dbg ? dbg_addr : core_addr;
                cap_wdata <= pick_dbg ? dbg_wdata : core_wdata;
            end
            if (state == ACC) begin
                core_done <= ~cap_dbg;
                dbg_done <= cap_dbg;
                if (!cap_we && cap_dbg) dbg_rdata <= ram_rd_byte;
                if (!cap_we && !cap_dbg) core_rdata <= ram_rd_byte;
            end
`ifdef RAM_ARB_BITOP_EN
            if (sfr_rej) core_done <= 1'b1;
            if (state == RMW_WR) begin
                core_done <= 1'b1;
                core_rdata <= {7'd0, cap_wdata[0]};
            end
`endif
        end
    end
    // Writes are gated by reset so an access interrupted by reset never lands.
    always_comb begin
        state_n = state;
        core_gnt = 1'b0;
        dbg_gnt = 1'b0;
        ram_rd_en_data = 1'b0;
        ram_wr_en_data = 1'b0;
        ram_rd_addr = 8'h00;
        ram_wr_addr = 8'h00;
        ram_wr_byte = 8'h00;
        case (state)
            IDLE: begin
`ifdef RAM_ARB_BITOP_EN
                if (any_req) state_n = !win_bit ? ACC : core_addr[7] ? IDLE : RMW_RD;
`else
                if (any_req) state_n = ACC;
`endif
            end
            ACC: begin
                core_gnt = ~cap_dbg;
                dbg_gnt = cap_dbg;
                ram_rd_en_data = ~cap_we;
                ram_wr_en_data = cap_we & ~reset;
                ram_rd_addr = cap_addr;
                ram_wr_addr = cap_addr;
                ram_wr_byte = cap_wdata;
                state_n = IDLE;
            end
`ifdef RAM_ARB_BITOP_EN
            RMW_RD: begin
                core_gnt = 1'b1;
                ram_rd_en_data = 1'b1;
                ram_rd_addr = bit_byte;
                state_n = RMW_WR;
            end
            RMW_WR: begin
                core_gnt = 1'b1;
                ram_wr_en_data = ~reset;
                ram_wr_addr = bit_byte;
                ram_wr_byte = bit_merged;
                state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule
